// File: rtl/prod_accum_pkg.sv
// prod_accum_pkg: shared state type and width helpers for the product accumulator
// Contents: state_t (ACC, HOLD), acc_w() accumulator width, cnt_w() beat-counter width
package prod_accum_pkg;

   typedef enum logic {ACC, HOLD} state_t;

   function automatic int acc_w(input int size, input int guard);
      return 2 * size + guard;
   endfunction

   // A single-product group still needs a 1-bit counter.
   function automatic int cnt_w(input int len);
      return len <= 1 ? 1 : $clog2(len);
   endfunction

endpackage

// File: rtl/prod_accum_if.sv
// prod_accum_if: product-in / result-out valid-ready bundle
// Ports (modport slave = accumulator side):
//   in_valid, in_data[2*SIZE]        product from multiplier (in_ready back)
//   out_valid, out_data[ACC_W], out_ovf   result to consumer (out_ready back)
interface prod_accum_if
   import prod_accum_pkg::*;
#(
   parameter int SIZE  = 8,
   parameter int GUARD = 4
);
   localparam int ACC_W = acc_w(SIZE, GUARD);

   logic                in_valid;
   logic                in_ready;
   logic [2*SIZE-1:0]   in_data;
   logic                out_valid;
   logic                out_ready;
   logic [ACC_W-1:0]    out_data;
   logic                out_ovf;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_ovf
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_ovf
   );

endinterface

// File: rtl/prod_accum_add.sv
// prod_accum_add: combinational W-bit unsigned adder returning sum and carry-out
// Ports: a, b [W] operands; sum [W] result; carry carry-out of the raw addition
// Macro PROD_ACCUM_SAT_EN: sum saturates to all-ones on carry-out instead of wrapping
module prod_accum_add #(
   parameter int W = 20
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] sum,
   output logic         carry
);

   logic [W:0] raw;

   always_comb begin
      raw   = {1'b0, a} + {1'b0, b};
      carry = raw[W];
`ifdef PROD_ACCUM_SAT_EN
      sum   = carry ? '1 : raw[W-1:0];
`else
      sum   = raw[W-1:0];
`endif
   end

endmodule

// File: rtl/prod_accum.sv
// prod_accum: sums LEN consecutive multiplier products into one result, held until taken
// Ports: clk; rst_n async active-low reset; clr sync clear (highest priority);
//        bus (prod_accum_if.slave) product in (valid/ready) and result out (valid/ready, ovf)
// Macro PROD_ACCUM_SAT_EN: saturating accumulation with sticky overflow reported in out_ovf
module prod_accum
   import prod_accum_pkg::*;
#(
   parameter int SIZE  = 8,
   parameter int LEN   = 4,
   parameter int GUARD = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   prod_accum_if.slave bus
);

   localparam int ACC_W = acc_w(SIZE, GUARD);
   localparam int CW    = cnt_w(LEN);
`ifdef PROD_ACCUM_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   state_t           state;
   logic [ACC_W-1:0] acc;
   logic [CW-1:0]    cnt;
   logic             ovf;
   logic [ACC_W-1:0] sum;
   logic             carry;
   logic             ovf_nxt;
   logic             last;

   prod_accum_add #(.W(ACC_W)) u_add (
      .a    (acc),
      .b    (ACC_W'(bus.in_data)),
      .sum  (sum),
      .carry(carry)
   );

   // Overflow only sticks in the saturating build; otherwise it stays 0.
   assign ovf_nxt      = ovf | (carry & SAT);
   assign last         = cnt == CW'(LEN - 1);
   assign bus.in_ready = state == ACC;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ACC;
         acc           <= '0;
         cnt           <= '0;
         ovf           <= 1'b0;
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_ovf   <= 1'b0;
      end else if (clr) begin
         state         <= ACC;
         acc           <= '0;
         cnt           <= '0;
         ovf           <= 1'b0;
         bus.out_valid <= 1'b0;
         bus.out_ovf   <= 1'b0;
      end else if (state == ACC) begin
         if (bus.in_valid) begin
            if (last) begin
               bus.out_data  <= sum;
               bus.out_ovf   <= ovf_nxt;
               bus.out_valid <= 1'b1;
               acc           <= '0;
               cnt           <= '0;
               ovf           <= 1'b0;
               state         <= HOLD;
            end else begin
               acc <= sum;
               cnt <= cnt + 1'b1;
               ovf <= ovf_nxt;
            end
         end
      end else if (bus.out_ready) begin
         bus.out_valid <= 1'b0;
         state         <= ACC;
      end
   end

endmodule

// File: tb/tb_prod_accum.sv
// tb_prod_accum: directed self-checking bench for prod_accum (LEN=4/GUARD=4 and LEN=2/GUARD=0 instances)
// Honours PROD_ACCUM_SAT_EN for the overflow expectations.
module tb_prod_accum;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic clr = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   prod_accum_if #(.SIZE(8), .GUARD(4)) a ();
   prod_accum_if #(.SIZE(8), .GUARD(0)) b ();

   prod_accum #(.SIZE(8), .LEN(4), .GUARD(4)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (clr),
      .bus  (a.slave)
   );

   prod_accum #(.SIZE(8), .LEN(2), .GUARD(0)) dut2 (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (clr),
      .bus  (b.slave)
   );

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic test_reset();
      a.in_valid = 0; a.in_data = 0; a.out_ready = 0;
      b.in_valid = 0; b.in_data = 0; b.out_ready = 0;
      rst_n = 0;
      tick(); tick();
      if (a.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0d exp 1", a.in_ready); end
      checks++;
      if (a.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0d exp 0", a.out_valid); end
      checks++;
      if (a.out_data !== 20'd0) begin errors++; $display("FAIL reset_out_data got %0d exp 0", a.out_data); end
      checks++;
      if (a.out_ovf !== 1'b0) begin errors++; $display("FAIL reset_out_ovf got %0d exp 0", a.out_ovf); end
      checks++;
      rst_n = 1;
      tick();
   endtask

   task automatic test_basic();
      a.out_ready = 1;
      a.in_valid = 1;
      a.in_data = 10; tick();
      if (a.out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %0d exp 0", a.out_valid); end
      checks++;
      a.in_data = 20; tick();
      a.in_data = 30; tick();
      a.in_data = 40; tick();
      a.in_valid = 0;
      if (a.out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %0d exp 1", a.out_valid); end
      checks++;
      if (a.out_data !== 20'd100) begin errors++; $display("FAIL basic_data got %0d exp 100", a.out_data); end
      checks++;
      if (a.in_ready !== 1'b0) begin errors++; $display("FAIL basic_in_ready_hold got %0d exp 0", a.in_ready); end
      checks++;
      tick();
      if (a.out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop got %0d exp 0", a.out_valid); end
      checks++;
      if (a.in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready_back got %0d exp 1", a.in_ready); end
      checks++;
   endtask

   task automatic test_backpressure();
      a.out_ready = 0;
      a.in_valid = 1;
      a.in_data = 16'd65025;
      repeat (4) tick();
      a.in_data = 7;
      for (int i = 0; i < 5; i++) begin
         if (a.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %0d exp 1", i, a.out_valid); end
         checks++;
         if (a.out_data !== 20'd260100) begin errors++; $display("FAIL bp_data[%0d] got %0d exp 260100", i, a.out_data); end
         checks++;
         if (a.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got %0d exp 0", i, a.in_ready); end
         checks++;
         tick();
      end
      a.out_ready = 1;
      a.in_valid = 0;
      if (a.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_at_ready got %0d exp 1", a.out_valid); end
      checks++;
      tick();
      if (a.out_valid !== 1'b0) begin errors++; $display("FAIL bp_handshake got %0d exp 0", a.out_valid); end
      checks++;
      if (a.in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_back got %0d exp 1", a.in_ready); end
      checks++;
   endtask

   task automatic test_gapped();
      a.out_ready = 1;
      for (int k = 1; k <= 4; k++) begin
         a.in_valid = 1;
         a.in_data = 16'(k);
         tick();
         a.in_valid = 0;
         if (k < 4) begin
            if (a.out_valid !== 1'b0) begin errors++; $display("FAIL gap_early_valid[%0d] got %0d exp 0", k, a.out_valid); end
            checks++;
            tick(); tick();
         end
      end
      if (a.out_valid !== 1'b1) begin errors++; $display("FAIL gap_valid got %0d exp 1", a.out_valid); end
      checks++;
      if (a.out_data !== 20'd10) begin errors++; $display("FAIL gap_data got %0d exp 10", a.out_data); end
      checks++;
      tick();
   endtask

   task automatic test_clr();
      a.out_ready = 1;
      a.in_valid = 1;
      a.in_data = 5; tick();
      a.in_data = 6; tick();
      clr = 1; a.in_data = 100; tick();
      clr = 0; a.in_valid = 0;
      if (a.out_valid !== 1'b0) begin errors++; $display("FAIL clr_valid got %0d exp 0", a.out_valid); end
      checks++;
      if (a.in_ready !== 1'b1) begin errors++; $display("FAIL clr_in_ready got %0d exp 1", a.in_ready); end
      checks++;
      a.in_valid = 1; a.in_data = 1;
      repeat (4) tick();
      a.in_valid = 0;
      if (a.out_valid !== 1'b1) begin errors++; $display("FAIL clr_group_valid got %0d exp 1", a.out_valid); end
      checks++;
      if (a.out_data !== 20'd4) begin errors++; $display("FAIL clr_group_data got %0d exp 4", a.out_data); end
      checks++;
      tick();
      // a held result is thrown away by clr
      a.out_ready = 0;
      a.in_valid = 1; a.in_data = 3;
      repeat (4) tick();
      a.in_valid = 0;
      if (a.out_data !== 20'd12) begin errors++; $display("FAIL clr_hold_data got %0d exp 12", a.out_data); end
      checks++;
      clr = 1; tick();
      clr = 0;
      if (a.out_valid !== 1'b0) begin errors++; $display("FAIL clr_discard_valid got %0d exp 0", a.out_valid); end
      checks++;
      if (a.in_ready !== 1'b1) begin errors++; $display("FAIL clr_discard_in_ready got %0d exp 1", a.in_ready); end
      checks++;
      tick();
      if (a.out_valid !== 1'b0) begin errors++; $display("FAIL clr_discard_stays got %0d exp 0", a.out_valid); end
      checks++;
      a.out_ready = 1;
   endtask

   task automatic test_overflow();
`ifdef PROD_ACCUM_SAT_EN
      logic [15:0] exp_data = 16'd65535;
      logic        exp_ovf  = 1'b1;
`else
      logic [15:0] exp_data = 16'd1;
      logic        exp_ovf  = 1'b0;
`endif
      b.out_ready = 1;
      b.in_valid = 1;
      b.in_data = 16'd65535; tick();
      b.in_data = 16'd2; tick();
      b.in_valid = 0;
      if (b.out_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid got %0d exp 1", b.out_valid); end
      checks++;
      if (b.out_data !== exp_data) begin errors++; $display("FAIL ovf_data got %0d exp %0d", b.out_data, exp_data); end
      checks++;
      if (b.out_ovf !== exp_ovf) begin errors++; $display("FAIL ovf_flag got %0d exp %0d", b.out_ovf, exp_ovf); end
      checks++;
      tick();
      b.in_valid = 1;
      b.in_data = 16'd1; tick();
      b.in_data = 16'd2; tick();
      b.in_valid = 0;
      if (b.out_data !== 16'd3) begin errors++; $display("FAIL ovf_next_data got %0d exp 3", b.out_data); end
      checks++;
      if (b.out_ovf !== 1'b0) begin errors++; $display("FAIL ovf_next_flag got %0d exp 0", b.out_ovf); end
      checks++;
      tick();
   endtask

   task automatic test_async_reset();
      a.out_ready = 1;
      a.in_valid = 1; a.in_data = 9;
      tick(); tick();
      a.in_valid = 0;
      #2 rst_n = 0;
      #1;
      if (a.out_data !== 20'd0) begin errors++; $display("FAIL arst_data got %0d exp 0", a.out_data); end
      checks++;
      if (a.out_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %0d exp 0", a.out_valid); end
      checks++;
      if (a.in_ready !== 1'b1) begin errors++; $display("FAIL arst_in_ready got %0d exp 1", a.in_ready); end
      checks++;
      if (b.out_data !== 16'd0) begin errors++; $display("FAIL arst_data2 got %0d exp 0", b.out_data); end
      checks++;
      tick();
      rst_n = 1;
      a.in_valid = 1;
      a.in_data = 1; tick();
      a.in_data = 2; tick();
      a.in_data = 3; tick();
      a.in_data = 4; tick();
      a.in_valid = 0;
      if (a.out_valid !== 1'b1) begin errors++; $display("FAIL arst_group_valid got %0d exp 1", a.out_valid); end
      checks++;
      if (a.out_data !== 20'd10) begin errors++; $display("FAIL arst_group_data got %0d exp 10", a.out_data); end
      checks++;
      tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_gapped();
      test_clr();
      test_overflow();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
